// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared PikaRISC widths, CPSR flag positions, queue entry type and flag merge
package wb_stage_pkg;
   localparam int PIKA_REG_NUM_W = 4;
   localparam int PIKA_REG_COUNT = 16;
   localparam int PIKA_DATA_W    = 32;
   localparam int CPSR_N = 31;
   localparam int CPSR_Z = 30;
   localparam int CPSR_C = 29;
   localparam int CPSR_V = 28;
   typedef struct packed {
      logic [PIKA_REG_NUM_W-1:0] rd_num;
      logic                      rd_en;
      logic [PIKA_DATA_W-1:0]    rd_data;
      logic                      cpsr_en;
      logic [3:0]                mask;
      logic [3:0]                flags;
   } wb_entry_t;
   // mask/flags bit3..0 land on N,Z,C,V; bits below V always come from base
   function automatic logic [PIKA_DATA_W-1:0] cpsr_merge(input logic [PIKA_DATA_W-1:0] base,
                                                         input logic [3:0] mask,
                                                         input logic [3:0] flags);
      logic [PIKA_DATA_W-1:0] m;
      m = PIKA_DATA_W'(mask) << CPSR_V;
      return (base & ~m) | ((PIKA_DATA_W'(flags) << CPSR_V) & m);
   endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order writeback queue with every slot visible for hazard tracking
//   push/din enqueue at the tail, pop retires the head; count, head, slot_vld and slots are exported
module wb_fifo
   import wb_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  wb_entry_t        din,
   output wb_entry_t        head,
   output logic [AW:0]      count,
   output logic [DEPTH-1:0] slot_vld,
   output wb_entry_t        slots [DEPTH]
);
   wb_entry_t     mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, off;
   logic [AW:0]   count_q, count_d;
   // pointers wrap for free because DEPTH is a power of two
   always_comb begin
      wr_d     = wr_q + AW'(push);
      rd_d     = rd_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      slot_vld = '0;
      off      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off         = AW'(i) - rd_q;
         slot_vld[i] = {1'b0, off} < count_q;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din;
   end
   assign head  = mem_q[rd_q];
   assign count = count_q;
   assign slots = mem_q;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage; queues retired results and drives one registered rd/CPSR write per cycle
//   in_*: valid/ready result from execute; hold stalls draining; cpsr_cur is the register file CPSR
//   wb_*: registered register-file write ports; pending_mask/cpsr_pending: in-flight writes; retire_count: pops
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int REG_NUM_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [REG_NUM_W-1:0]    in_rd_num,
   input  logic                    in_rd_en,
   input  logic [31:0]             in_rd_data,
   input  logic                    in_cpsr_en,
   input  logic [3:0]              in_cpsr_mask,
   input  logic [3:0]              in_cpsr_flags,
   input  logic                    hold,
   input  logic [31:0]             cpsr_cur,
   output logic [REG_NUM_W-1:0]    wb_rd_num,
   output logic                    wb_rd_write_en,
   output logic [31:0]             wb_rd_in,
   output logic                    wb_cpsr_write_en,
   output logic [31:0]             wb_cpsr_in,
   output logic [2**REG_NUM_W-1:0] pending_mask,
   output logic                    cpsr_pending,
   output logic [31:0]             retire_count
);
   localparam int AW = $clog2(DEPTH);
   logic                 push, pop;
   wb_entry_t            din, head;
   wb_entry_t            slots [DEPTH];
   logic [AW:0]          count;
   logic [DEPTH-1:0]     slot_vld;
   logic [REG_NUM_W-1:0] wb_rd_num_q, wb_rd_num_d;
   logic                 wb_rd_write_en_q, wb_rd_write_en_d;
   logic [31:0]          wb_rd_in_q, wb_rd_in_d;
   logic                 wb_cpsr_write_en_q, wb_cpsr_write_en_d;
   logic [31:0]          wb_cpsr_in_q, wb_cpsr_in_d;
   logic [31:0]          retire_count_q, retire_count_d;
   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .din      (din),
      .head     (head),
      .count    (count),
      .slot_vld (slot_vld),
      .slots    (slots)
   );
   // ready ignores a same-cycle pop so it never depends on hold
   always_comb begin
      in_ready           = !reset && (int'(count) < DEPTH);
      push               = in_valid && in_ready;
      pop                = (count != '0) && !hold;
      din                = '{rd_num: in_rd_num, rd_en: in_rd_en, rd_data: in_rd_data,
                             cpsr_en: in_cpsr_en, mask: in_cpsr_mask, flags: in_cpsr_flags};
      wb_rd_num_d        = pop ? head.rd_num : wb_rd_num_q;
      wb_rd_write_en_d   = pop && head.rd_en;
      wb_rd_in_d         = pop ? head.rd_data : wb_rd_in_q;
      wb_cpsr_write_en_d = pop && head.cpsr_en;
      // chained flag writes merge onto the value still in flight to the register file
      wb_cpsr_in_d       = pop ? cpsr_merge(wb_cpsr_write_en_q ? wb_cpsr_in_q : cpsr_cur, head.mask, head.flags)
                               : wb_cpsr_in_q;
      retire_count_d     = retire_count_q + 32'(pop);
      pending_mask       = wb_rd_write_en_q ? (2**REG_NUM_W)'(1) << wb_rd_num_q : '0;
      cpsr_pending       = wb_cpsr_write_en_q;
      for (int i = 0; i < DEPTH; i++) begin
         pending_mask = pending_mask | ((slot_vld[i] && slots[i].rd_en) ? (2**REG_NUM_W)'(1) << slots[i].rd_num : '0);
         cpsr_pending = cpsr_pending | (slot_vld[i] && slots[i].cpsr_en);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_rd_num_q        <= '0;
         wb_rd_write_en_q   <= 1'b0;
         wb_rd_in_q         <= '0;
         wb_cpsr_write_en_q <= 1'b0;
         wb_cpsr_in_q       <= '0;
         retire_count_q     <= '0;
      end else begin
         wb_rd_num_q        <= wb_rd_num_d;
         wb_rd_write_en_q   <= wb_rd_write_en_d;
         wb_rd_in_q         <= wb_rd_in_d;
         wb_cpsr_write_en_q <= wb_cpsr_write_en_d;
         wb_cpsr_in_q       <= wb_cpsr_in_d;
         retire_count_q     <= retire_count_d;
      end
   end
   assign wb_rd_num        = wb_rd_num_q;
   assign wb_rd_write_en   = wb_rd_write_en_q;
   assign wb_rd_in         = wb_rd_in_q;
   assign wb_cpsr_write_en = wb_cpsr_write_en_q;
   assign wb_cpsr_in       = wb_cpsr_in_q;
   assign retire_count     = retire_count_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus against a queue-level model of the writeback stage
module tb_wb_stage;
   localparam int DEPTH = 2;
   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, in_rd_en, in_cpsr_en, hold;
   logic [3:0]  in_rd_num, in_cpsr_mask, in_cpsr_flags, wb_rd_num;
   logic [31:0] in_rd_data, cpsr_cur, wb_rd_in, wb_cpsr_in, retire_count;
   logic        wb_rd_write_en, wb_cpsr_write_en, cpsr_pending;
   logic [15:0] pending_mask;
   always #5 clk = ~clk;
   wb_stage #(.DEPTH(DEPTH), .REG_NUM_W(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd_num(in_rd_num), .in_rd_en(in_rd_en), .in_rd_data(in_rd_data),
      .in_cpsr_en(in_cpsr_en), .in_cpsr_mask(in_cpsr_mask), .in_cpsr_flags(in_cpsr_flags),
      .hold(hold), .cpsr_cur(cpsr_cur), .wb_rd_num(wb_rd_num), .wb_rd_write_en(wb_rd_write_en),
      .wb_rd_in(wb_rd_in), .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_in(wb_cpsr_in),
      .pending_mask(pending_mask), .cpsr_pending(cpsr_pending), .retire_count(retire_count)
   );
   typedef struct {
      logic [3:0]  num;
      logic        ren;
      logic [31:0] data;
      logic        cen;
      logic [3:0]  mask;
      logic [3:0]  flags;
   } ent_t;
   ent_t        q[$];
   logic        m_wen, m_cwe;
   logic [3:0]  m_num;
   logic [31:0] m_data, m_cin, m_cnt;
   bit          started, wrap_req;
   int          n_pass, n_tot;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask
   always @(posedge clk) begin : model
      ent_t        e;
      logic [31:0] base;
      bit          acc;
      started = 1'b1;
      if (reset) begin
         q.delete();
         m_wen = 0; m_cwe = 0; m_num = 0; m_data = 0; m_cin = 0; m_cnt = 0;
      end else begin
         acc = in_valid && q.size() < DEPTH;
         if (wrap_req) m_cnt = '1;
         if (q.size() > 0 && !hold) begin
            e = q.pop_front();
            base = m_cwe ? m_cin : cpsr_cur;
            for (int f = 0; f < 4; f++) if (e.mask[f]) base[28+f] = e.flags[f];
            m_cin = base; m_num = e.num; m_data = e.data; m_wen = e.ren; m_cwe = e.cen;
            m_cnt = m_cnt + 1;
         end else begin
            m_wen = 0; m_cwe = 0;
         end
         if (acc) q.push_back('{in_rd_num, in_rd_en, in_rd_data, in_cpsr_en, in_cpsr_mask, in_cpsr_flags});
      end
   end
   always @(negedge clk) begin : compare
      logic [15:0] pm;
      logic        cp;
      if (started) begin
         pm = m_wen ? 16'd1 << m_num : 16'd0;
         cp = m_cwe;
         foreach (q[i]) begin
            if (q[i].ren) pm[q[i].num] = 1'b1;
            if (q[i].cen) cp = 1'b1;
         end
         chk("model in_ready", 32'(in_ready), 32'(!reset && q.size() < DEPTH));
         chk("model wb_rd_write_en", 32'(wb_rd_write_en), 32'(m_wen));
         chk("model wb_rd_num", 32'(wb_rd_num), 32'(m_num));
         chk("model wb_rd_in", wb_rd_in, m_data);
         chk("model wb_cpsr_write_en", 32'(wb_cpsr_write_en), 32'(m_cwe));
         chk("model wb_cpsr_in", wb_cpsr_in, m_cin);
         chk("model pending_mask", 32'(pending_mask), 32'(pm));
         chk("model cpsr_pending", 32'(cpsr_pending), 32'(cp));
         chk("model retire_count", retire_count, wrap_req ? 32'hFFFF_FFFF : m_cnt);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic put(input logic [3:0] num, input logic ren, input logic [31:0] data,
                      input logic cen, input logic [3:0] mask, input logic [3:0] flags);
      in_valid = 1; in_rd_num = num; in_rd_en = ren; in_rd_data = data;
      in_cpsr_en = cen; in_cpsr_mask = mask; in_cpsr_flags = flags;
   endtask
   task automatic idle();
      in_valid = 0; in_rd_en = 0; in_cpsr_en = 0; in_cpsr_mask = 0; in_cpsr_flags = 0;
      in_rd_num = 0; in_rd_data = 0;
   endtask
   initial begin
      reset = 1; hold = 0; cpsr_cur = 32'h0000_00A5; wrap_req = 0;
      idle();
      tick(); tick();
      reset = 0;
      #1 chk("reset in_ready", 32'(in_ready), 1);
      chk("reset retire_count", retire_count, 0);
      chk("reset wb_rd_write_en", 32'(wb_rd_write_en), 0);
      put(4'd3, 1, 32'hDEAD_BEEF, 0, 0, 0);
      tick(); idle();
      #1 chk("single no early strobe", 32'(wb_rd_write_en), 0);
      tick();
      #1 chk("single strobe", 32'(wb_rd_write_en), 1);
      chk("single rd_num", 32'(wb_rd_num), 3);
      chk("single rd_in", wb_rd_in, 32'hDEAD_BEEF);
      tick();
      #1 chk("single strobe one cycle", 32'(wb_rd_write_en), 0);
      chk("single retire_count", retire_count, 1);
      put(4'd0, 0, 0, 1, 4'b1000, 4'b1000);
      tick();
      put(4'd0, 0, 0, 1, 4'b0100, 4'b0100);
      tick(); idle();
      #1 chk("flags first strobe", 32'(wb_cpsr_write_en), 1);
      chk("flags first value", wb_cpsr_in, 32'h8000_00A5);
      tick();
      #1 chk("flags second strobe", 32'(wb_cpsr_write_en), 1);
      chk("flags second value", wb_cpsr_in, 32'hC000_00A5);
      tick();
      hold = 1;
      put(4'd1, 1, 32'h11, 0, 0, 0);
      tick();
      put(4'd2, 1, 32'h22, 0, 0, 0);
      tick();
      put(4'd4, 1, 32'h44, 0, 0, 0);
      #1 chk("full in_ready", 32'(in_ready), 0);
      chk("full pending_mask", 32'(pending_mask), 32'h0006);
      tick();
      #1 chk("full still waiting", 32'(in_ready), 0);
      chk("hold no strobe", 32'(wb_rd_write_en), 0);
      hold = 0;
      tick();
      #1 chk("drain first rd", 32'(wb_rd_num), 1);
      chk("drain first strobe", 32'(wb_rd_write_en), 1);
      tick(); idle();
      #1 chk("drain second rd", 32'(wb_rd_num), 2);
      tick();
      #1 chk("drain third rd", 32'(wb_rd_num), 4);
      chk("drain third data", wb_rd_in, 32'h44);
      tick();
      put(4'd0, 0, 0, 0, 0, 0);
      tick();
      put(4'd15, 1, 32'h1, 0, 0, 0);
      tick();
      put(4'd0, 0, 0, 1, 4'b0010, 4'b0010);
      #1 chk("nop no rd strobe", 32'(wb_rd_write_en), 0);
      chk("nop no cpsr strobe", 32'(wb_cpsr_write_en), 0);
      chk("r15 pending queued", 32'(pending_mask[15]), 1);
      tick(); idle();
      #1 chk("r15 strobe", 32'(wb_rd_num), 15);
      chk("r15 pending in strobe", 32'(pending_mask[15]), 1);
      chk("cpsr pending queued", 32'(cpsr_pending), 1);
      tick();
      #1 chk("r15 pending cleared", 32'(pending_mask[15]), 0);
      chk("cpsr-only value", wb_cpsr_in, 32'h2000_00A5);
      chk("cpsr pending in strobe", 32'(cpsr_pending), 1);
      tick();
      #1 chk("cpsr pending cleared", 32'(cpsr_pending), 0);
      hold = 1;
      put(4'd5, 1, 32'h55, 0, 0, 0);
      tick();
      put(4'd6, 1, 32'h66, 0, 0, 0);
      tick();
      reset = 1;
      put(4'd7, 1, 32'h77, 0, 0, 0);
      tick();
      reset = 0; hold = 0; idle();
      #1 chk("midreset no strobe", 32'(wb_rd_write_en), 0);
      chk("midreset pending", 32'(pending_mask), 0);
      chk("midreset retire_count", retire_count, 0);
      tick();
      #1 chk("midreset queue empty", 32'(wb_rd_write_en), 0);
      hold = 1;
      put(4'd7, 1, 32'h77, 0, 0, 0);
      tick(); idle();
      #1 force dut.retire_count_q = 32'hFFFF_FFFF;
      wrap_req = 1;
      #1 release dut.retire_count_q;
      #1 chk("wrap forced", retire_count, 32'hFFFF_FFFF);
      hold = 0;
      tick();
      wrap_req = 0;
      #1 chk("wrap to zero", retire_count, 0);
      chk("wrap strobe rd", 32'(wb_rd_num), 7);
      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
